// File: rtl/test.sv
// One-bit full adder. With REGISTER_OUTPUTS=1 the sum/carry pass through a single
// asynchronously reset register stage; with 0 the outputs are purely combinational.
module test #(
    parameter bit REGISTER_OUTPUTS = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic D,
    output logic E
);

    logic sum;
    logic carry;

    // Plain operators so an X/Z on any input propagates instead of being defaulted.
    always_comb begin
        sum   = A ^ B ^ C;
        carry = (A & B) | (A & C) | (B & C);
    end

    generate
        if (REGISTER_OUTPUTS) begin : g_reg
            logic d_d;
            logic d_q;
            logic e_d;
            logic e_q;

            always_comb begin
                d_d = sum;
                e_d = carry;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_q <= 1'b0;
                    e_q <= 1'b0;
                end else begin
                    d_q <= d_d;
                    e_q <= e_d;
                end
            end

            assign D = d_q;
            assign E = e_q;
        end else begin : g_comb
            // Clock and reset are intentionally unused in this configuration.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign D = sum;
            assign E = carry;
        end
    endgenerate

endmodule

// File: tb/tb_test.sv
// Self-checking bench for the full adder: a registered instance checked through an
// expected-value queue, and a combinational instance checked in the same timestep.
module tb_test;

    logic clk;
    logic rst;
    logic A;
    logic B;
    logic C;
    logic d_reg;
    logic e_reg;
    logic d_comb;
    logic e_comb;

    int n_cmp;
    int n_err;
    logic [1:0] exp_q[$];

    test #(.REGISTER_OUTPUTS(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .C  (C),
        .D  (d_reg),
        .E  (e_reg)
    );

    test #(.REGISTER_OUTPUTS(1'b0)) dut_comb (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .C  (C),
        .D  (d_comb),
        .E  (e_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Values are {E,D}.
    task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: obs {E,D}=%b exp {E,D}=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

    // Drive one sample at the falling edge and compare after the following rising edge.
    task automatic drive(input string tag, input logic a, input logic b, input logic c);
        logic [1:0] exp;
        @(negedge clk);
        A = a;
        B = b;
        C = c;
        exp_q.push_back(model(a, b, c));
        #1;
        check_eq({tag, "_comb"}, {e_comb, d_comb}, model(a, b, c));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_empty"}, {e_reg, d_reg}, 2'bxx);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, {e_reg, d_reg}, exp);
        end
    endtask

    initial begin
        logic [1:0] held;
        n_cmp = 0;
        n_err = 0;

        // Reset with all inputs high, checked before the first clock edge.
        rst = 1'b1;
        A   = 1'b1;
        B   = 1'b1;
        C   = 1'b1;
        #2;
        check_eq("rst_async", {e_reg, d_reg}, 2'b00);
        check_eq("rst_comb_ignores", {e_comb, d_comb}, 2'b11);
        #6;
        check_eq("rst_hold_edge", {e_reg, d_reg}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        drive("s000", 1'b0, 1'b0, 1'b0);
        drive("s001", 1'b0, 1'b0, 1'b1);
        drive("s010", 1'b0, 1'b1, 1'b0);
        drive("s011", 1'b0, 1'b1, 1'b1);
        drive("s100", 1'b1, 1'b0, 1'b0);
        drive("s101", 1'b1, 1'b0, 1'b1);
        drive("s110", 1'b1, 1'b1, 1'b0);
        drive("s111", 1'b1, 1'b1, 1'b1);

        // Input glitches between edges must not disturb the registered outputs.
        held = {e_reg, d_reg};
        #1;
        A = 1'b0;
        #1;
        B = 1'b0;
        #1;
        check_eq("glitch_hold", {e_reg, d_reg}, held);
        check_eq("glitch_comb", {e_comb, d_comb}, model(1'b0, 1'b0, 1'b1));
        A = 1'b1;
        B = 1'b1;
        @(posedge clk);
        #1;
        check_eq("glitch_reload", {e_reg, d_reg}, 2'b11);

        // Reset pulse between edges while outputs are 1,1.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_drop", {e_reg, d_reg}, 2'b00);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_mid_stay", {e_reg, d_reg}, 2'b00);
        @(posedge clk);
        #1;
        check_eq("rst_mid_reload", {e_reg, d_reg}, 2'b11);

        // Reset held across an edge discards the pending sample.
        @(negedge clk);
        A = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_over_edge", {e_reg, d_reg}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_after_rel", {e_reg, d_reg}, 2'b00);
        drive("post_rst", 1'b1, 1'b0, 1'b0);

        // Combinational instance tracks inputs with the clock ignored.
        for (int i = 0; i < 12; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            #1;
            A = v[2];
            B = v[1];
            C = v[0];
            #0;
            #0;
            check_eq($sformatf("comb_track%0d", i), {e_comb, d_comb}, model(v[2], v[1], v[0]));
        end

        check_eq("queue_empty", 2'(exp_q.size()), 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
